nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle add/subtract sequencer that computes a 4·NIBBLES-bit sum by reusing one 4-bit ripple-carry stage, least-significant nibble first, one nibble per clock. The 4-bit stage is built from the team's `full_adder` cells, with a registered carry closing the loop between nibbles. The block sits between a requester issuing start/operand pulses and any consumer that needs wide sums but can tolerate NIBBLES+1 cycles of latency in exchange for minimal adder area.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range 2..16.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = A+B, 1 = A−B; latched with operands.
- a  in  W  operand A; latched on accepted start.
- b  in  W  operand B; latched on accepted start.
- busy  out  1  high while nibbles are being computed.
- done  out  1  one-cycle pulse; result outputs valid.
- sum  out  W  result.
- cout  out  1  final carry out; for sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - busy=0, done=0.
  - start=1 → latch a, b, sub; carry register ← sub; nibble index ← 0; go to RUN.
- **RUN:**
  - busy=1.
  - Each cycle the stage adds a[idx], b[idx]^{4{sub}} and the carry register.
  - Result nibble is written to sum[4·idx+3:4·idx]; carry register ← stage carry; idx ← idx+1.
  - When idx = NIBBLES−1: write the last nibble, cout ← stage carry, ovf ← computed, go to DONE.
- **DONE:**
  - done=1, busy=0.
  - start=1 → accepted exactly as in IDLE, going directly to RUN (back-to-back operation).
  - start=0 → IDLE.
- Overflow rule: with B' = b^{W{sub}}, ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]).
- Arithmetic is modulo 2^W. No carry-in port; the initial carry is sub only.
- start while busy=1 is ignored: no operand re-latch, no queueing, no effect on the current operation.
- sum, cout and ovf hold their last values in IDLE.
  - During RUN, sum is partially overwritten nibble by nibble; it is valid only when done=1 and thereafter until the next accepted start.
- Operand inputs a, b and sub may change freely after the accept edge.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0, idx=0.
  - The operation in progress is discarded.
- Release: first start can be sampled on the first rising edge after rst_n deasserts.
- Accept edge E: busy=1 from E until E+NIBBLES.
- done=1 for exactly the cycle between edges E+NIBBLES and E+NIBBLES+1.
- Latency from accept edge to done visible: NIBBLES edges (4 for default). Throughput: one operation per NIBBLES+1 cycles with back-to-back starts.
- Nibble k of sum is final after edge E+k+1.
- Carry path per cycle: one 4-bit ripple (four full-adder delays) plus the carry register; no combinational path from inputs to outputs.

## Test plan
- **Basic add:** a=0x1234, b=0x0FCC, sub=0 → after 4 edges done=1, sum=0x2200, cout=0, ovf=0; busy high exactly 4 cycles.
- **Carry ripple across all nibbles and signed overflow:**
  - a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- **Subtract:**
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0 (borrow), ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- **Start while busy:** start a=0x0001, b=0x0001, then assert start with a=0xAAAA, b=0x5555 during RUN cycles 1–3 → first result 0x0002 with a single done pulse; second request never executed.
- **Back-to-back:** hold start=1 with a new operand pair in the DONE cycle → busy re-asserts on the next edge with no IDLE cycle; both done pulses carry correct sums; total 10 cycles for two ops.
- **Reset mid-operation:** drop rst_n asynchronously after 2 RUN edges → outputs immediately reset to 0, no done pulse; after release, a fresh op (0x00FF+0x0001 → 0x0100) completes normally.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add/subtract computed one nibble per clock,
// least-significant nibble first, through a single 4-bit ripple stage.
// A registered carry links each nibble to the next one.
//
// Handshake: on a rising edge where start=1 and busy=0 (state IDLE or DONE),
// a, b and sub are latched and busy rises. While busy=1, start is ignored.
// done pulses high for one cycle when sum/cout/ovf are final. The results
// remain valid until the next accepted start.

// One-bit full adder cell used to build the 4-bit ripple stage.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            sub_r;
  logic            carry;
  logic [IW-1:0]   idx;

  // Nibble slice currently being processed. For a subtract, B is inverted here,
  // and the initial carry of 1 completes the two's complement.
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  logic [4:0] c;
  logic       last;
  logic       ovf_next;

  assign nib_a = a_r[4*idx +: 4];
  assign nib_b = b_r[4*idx +: 4] ^ {4{sub_r}};
  assign c[0]  = carry;
  assign last  = (idx == IW'(NIBBLES - 1));

  // Signed overflow: the operands have the same sign, and the result sign differs.
  assign ovf_next = (a_r[W-1] == (b_r[W-1] ^ sub_r)) && (nib_s[3] != a_r[W-1]);

  for (genvar i = 0; i < 4; i++) begin : g_stage
    full_adder u_fa (
      .x  (nib_a[i]),
      .y  (nib_b[i]),
      .ci (c[i]),
      .s  (nib_s[i]),
      .co (c[i+1])
    );
  end

  // Sequencer: accept the operands, walk the nibbles, then present the result for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= nib_s;
          carry           <= c[4];
          if (last) begin
            cout  <= c[4];
            ovf   <= ovf_next;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4, W=16).
// It uses a table of known vectors, hand-written multi-cycle sequences, and random
// operations that are checked against a signed/unsigned arithmetic reference model.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  // Each expected-queue entry holds {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the unsigned and signed views of the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    longint m  = longint'(1) << W;
    longint ua = longint'(ta);
    longint ub = longint'(tb);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint r;
    longint rs;
    logic   c;
    logic   o;
    logic [W-1:0] s;
    if (ts) begin
      r  = ua - ub;
      rs = sa - sb;
      c  = (ua >= ub);
    end else begin
      r  = ua + ub;
      rs = sa + sb;
      c  = (r >= m);
    end
    s = W'(((r % m) + m) % m);
    o = (rs > m / 2 - 1) || (rs < -(m / 2));
    return {o, c, s};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_sum",  64'(sum),  64'(mon_e[W-1:0]));
        check("sb_cout", 64'(cout), 64'(mon_e[W]));
        check("sb_ovf",  64'(ovf),  64'(mon_e[W+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request, let the next rising edge accept it, and return 1ns after that edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       output int acc_cyc);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb, ts));
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  // Run one full operation with no back-to-back start. Check the busy window, the done pulse, and the hold behaviour.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
    int acc;
    issue(ta, tb, ts, acc);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("busy_run", 64'(busy), 64'(1));
      check("done_run", 64'(done), 64'(0));
    end
    @(negedge clk);
    check("busy_at_done", 64'(busy), 64'(0));
    check("done_pulse", 64'(done), 64'(1));
    rs = sum; rc = cout; ro = ovf;
    @(negedge clk);
    check("done_clear", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("sum_hold", 64'(sum), 64'(rs));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           acc1;
    int           acc2;
    int           dc0;

    vecs[0] = '{16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum",  64'(sum),  64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf",  64'(ovf),  64'(0));
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro);
      check($sformatf("vec%0d_sum", i),  64'(rs), 64'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].c));
      check($sformatf("vec%0d_ovf", i),  64'(ro), 64'(vecs[i].o));
    end

    // A start issued while busy must be ignored.
    issue(16'h0001, 16'h0001, 1'b0, acc1);
    dc0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_start_done_cnt", 64'(done_cnt - dc0), 64'(1));
    check("busy_start_sum", 64'(sum), 64'(16'h0002));
    check("busy_start_q_empty", 64'(exp_q.size()), 64'(0));

    // Back-to-back: a new start during the DONE cycle.
    issue(16'h1111, 16'h2222, 1'b0, acc1);
    repeat (N) @(negedge clk);
    @(negedge clk);
    check("b2b_done1", 64'(done), 64'(1));
    issue(16'h4000, 16'h0001, 1'b1, acc2);
    @(negedge clk);
    check("b2b_busy_again", 64'(busy), 64'(1));
    repeat (N - 1) @(negedge clk);
    @(negedge clk);
    check("b2b_done2", 64'(done), 64'(1));
    check("b2b_total_cycles", 64'(cyc - acc1 + 1), 64'(10));
    @(negedge clk);
    check("b2b_done_clear", 64'(done), 64'(0));

    // Reset during RUN. The previous op left cout=1 and ovf=1 so the clear is visible.
    run_op(16'h8000, 16'h0001, 1'b1, rs, rc, ro);
    issue(16'hFFFF, 16'hFFFF, 1'b0, acc1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    dc0 = done_cnt;
    check("mid_rst_sum",  64'(sum),  64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_cout", 64'(cout), 64'(0));
    check("mid_rst_ovf",  64'(ovf),  64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt - dc0), 64'(0));
    run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro);
    check("post_rst_sum", 64'(rs), 64'(16'h0100));

    // Randomized operations, checked through the scoreboard.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), rs, rc, ro);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("final_q_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
